// File: rtl/ccff_loader_if.sv
// Word handshake between a configuration-word source and the ccff_loader.
// The source drives data/valid; the loader answers with ready.
interface ccff_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ccff_loader.sv
// Serialises configuration words LSB-first into a CCFF chain of CHAIN_LEN bits,
// one word per handshake, with abort and registered status outputs.
module ccff_loader #(
  parameter  int WORD_W    = 8,
  parameter  int CHAIN_LEN = 64,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic             prog_clk,
  input  logic             pReset,
  input  logic             start,
  input  logic             abort,
  ccff_loader_if.slave     in_if,
  output logic             ccff_head,
  output logic             ccff_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int WCNT_W = $clog2(WORD_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0]  CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [WCNT_W-1:0] WORD_W_C    = WCNT_W'(WORD_W);

  logic [1:0]        state_q,   state_d;
  logic [WORD_W-1:0] shreg_q,   shreg_d;
  logic [WCNT_W-1:0] wcnt_q,    wcnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              head_q,    head_d;
  logic              en_q,      en_d;
  logic              ready_q,   ready_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  logic [CNT_W-1:0]  bit_inc;
  logic [WCNT_W-1:0] wcnt_inc;
  logic              handshake;

  assign bit_inc   = bit_cnt_q + CNT_W'(1);
  assign wcnt_inc  = wcnt_q + WCNT_W'(1);
  assign handshake = in_if.in_valid & ready_q;

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    wcnt_d    = wcnt_q;
    bit_cnt_d = bit_cnt_q;
    head_d    = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      shreg_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_LOAD;
            bit_cnt_d = '0;
          end
        end
        S_LOAD: begin
          if (handshake) begin
            // Bit 0 goes straight to the head register so it appears the cycle after acceptance.
            state_d = S_SHIFT;
            head_d  = in_if.in_data[0];
            shreg_d = in_if.in_data >> 1;
            wcnt_d  = '0;
          end
        end
        S_SHIFT: begin
          bit_cnt_d = bit_inc;
          wcnt_d    = wcnt_inc;
          if (bit_inc == CHAIN_LEN_C) begin
            // Chain full: any unshifted upper bits of a partial final word are dropped.
            state_d = S_DONE;
            shreg_d = '0;
          end else if (wcnt_inc == WORD_W_C) begin
            state_d = S_LOAD;
          end else begin
            head_d  = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    en_d    = (state_d == S_SHIFT);
    ready_d = (state_d == S_LOAD);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      wcnt_q    <= '0;
      bit_cnt_q <= '0;
      head_q    <= 1'b0;
      en_q      <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      wcnt_q    <= wcnt_d;
      bit_cnt_q <= bit_cnt_d;
      head_q    <= head_d;
      en_q      <= en_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign in_if.in_ready = ready_q;
  assign ccff_head      = head_q;
  assign ccff_en        = en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign bit_cnt        = bit_cnt_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: a 64-bit chain instance and a 20-bit
// truncating instance, checked against hand-computed bit streams.
module tb_ccff_loader;

  logic clk = 1'b0;
  logic rst_n;

  logic       a_start, a_abort, a_head, a_en, a_busy, a_done;
  logic [6:0] a_bit_cnt;
  logic       b_start, b_abort, b_head, b_en, b_busy, b_done;
  logic [4:0] b_bit_cnt;

  ccff_loader_if #(.WORD_W(8)) a_if ();
  ccff_loader_if #(.WORD_W(8)) b_if ();

  ccff_loader #(.WORD_W(8), .CHAIN_LEN(64)) u_a (
    .prog_clk (clk),      .pReset (rst_n),     .start (a_start), .abort (a_abort),
    .in_if    (a_if),     .ccff_head (a_head), .ccff_en (a_en),  .busy (a_busy),
    .done     (a_done),   .bit_cnt (a_bit_cnt)
  );

  ccff_loader #(.WORD_W(8), .CHAIN_LEN(20)) u_b (
    .prog_clk (clk),      .pReset (rst_n),     .start (b_start), .abort (b_abort),
    .in_if    (b_if),     .ccff_head (b_head), .ccff_en (b_en),  .busy (b_busy),
    .done     (b_done),   .bit_cnt (b_bit_cnt)
  );

  initial forever #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int head_err    = 0;
  int a_done_cnt, b_done_cnt, a_first_en, b_max;
  logic a_stream[$];
  logic b_stream[$];
  logic [7:0] words [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

  int gap_rdy, gap_en, first_hs, timed_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: wait for the edge, then sample both instances mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    if (a_en) a_stream.push_back(a_head);
    if (b_en) b_stream.push_back(b_head);
    if (a_en && a_first_en < 0) a_first_en = cycle;
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
    if ((!a_en && a_head) || (!b_en && b_head)) head_err++;
    if (int'(b_bit_cnt) > b_max) b_max = int'(b_bit_cnt);
  endtask

  // Feeds words 0x01..0x08 into instance A; optional gap before word 4,
  // abort / async reset at a given bit_cnt, or a stray start at a given bit_cnt.
  task automatic load_a(input int gap_len, input int abort_at, input int reset_at,
                        input int start_at);
    int   idx = 0;
    int   gap = 0;
    logic hs, st;
    a_stream.delete();
    a_done_cnt = 0; a_first_en = -1; first_hs = -1;
    gap_rdy = 0; gap_en = 0; timed_out = 1;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (a_done_cnt > 0 || !a_busy) begin timed_out = 0; break; end
      if (abort_at >= 0 && a_en && int'(a_bit_cnt) == abort_at) begin
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        timed_out = 0;
        break;
      end
      if (reset_at >= 0 && a_en && int'(a_bit_cnt) == reset_at) begin
        #3 rst_n = 1'b0;
        #1;
        timed_out = 0;
        break;
      end
      a_if.in_data  = (idx < 8) ? words[idx] : 8'h00;
      a_if.in_valid = (idx < 8);
      if (idx == 3 && gap < gap_len && (gap > 0 || a_if.in_ready)) begin
        a_if.in_valid = 1'b0;
        gap++;
        gap_rdy += int'(a_if.in_ready);
        gap_en  += int'(a_en);
      end
      st = (start_at >= 0 && a_en && int'(a_bit_cnt) == start_at);
      a_start = st;
      hs = a_if.in_valid && a_if.in_ready;
      if (hs && first_hs < 0) first_hs = cycle;
      step();
      a_start = 1'b0;
      if (st) check("start_ignored_bit_cnt", 64'(a_bit_cnt), 64'(start_at + 1));
      if (hs) idx++;
    end
    a_if.in_valid = 1'b0;
    check("a_timeout", 64'(timed_out), 64'd0);
  endtask

  task automatic check_full_stream(input string tag);
    logic [63:0] s = '0;
    for (int i = 0; i < 64 && i < a_stream.size(); i++) s[i] = a_stream[i];
    check({tag, "_en_cycles"}, 64'(a_stream.size()), 64'd64);
    check({tag, "_stream"}, s, 64'h0807_0605_0403_0201);
    check({tag, "_done_pulses"}, 64'(a_done_cnt), 64'd1);
    check({tag, "_bit_cnt"}, 64'(a_bit_cnt), 64'd64);
  endtask

  initial begin
    int hs_b, last_bits, ones;
    logic hs;
    rst_n = 1'b0;
    a_start = 1'b0; a_abort = 1'b0; a_if.in_data = '0; a_if.in_valid = 1'b0;
    b_start = 1'b0; b_abort = 1'b0; b_if.in_data = '0; b_if.in_valid = 1'b0;
    a_first_en = -1; a_done_cnt = 0; b_done_cnt = 0; b_max = 0;
    repeat (3) step();
    check("rst_busy",    64'(a_busy),          64'd0);
    check("rst_en",      64'(a_en),            64'd0);
    check("rst_ready",   64'(a_if.in_ready),   64'd0);
    check("rst_done",    64'(a_done),          64'd0);
    check("rst_bit_cnt", 64'(a_bit_cnt),       64'd0);
    check("rst_head",    64'(a_head),          64'd0);
    #2 rst_n = 1'b1;
    repeat (3) step();
    check("idle_hold_busy", 64'(a_busy | b_busy), 64'd0);

    // Full 64-bit load with valid held high.
    load_a(0, -1, -1, -1);
    check_full_stream("full");
    check("first_bit_latency", 64'(a_first_en - first_hs), 64'd1);
    step();
    check("after_done_busy",    64'(a_busy),    64'd0);
    check("after_done_bit_cnt", 64'(a_bit_cnt), 64'd64);

    // Same load with a 5-cycle valid gap before word 4.
    load_a(5, -1, -1, -1);
    check_full_stream("gap");
    check("gap_ready_cycles", 64'(gap_rdy), 64'd5);
    check("gap_en_cycles",    64'(gap_en),  64'd0);
    step();

    // Abort mid-shift at bit_cnt 13.
    load_a(0, 13, -1, -1);
    check("abort_en",    64'(a_en),           64'd0);
    check("abort_busy",  64'(a_busy),         64'd0);
    check("abort_ready", 64'(a_if.in_ready),  64'd0);
    repeat (5) step();
    check("abort_no_done", 64'(a_done_cnt), 64'd0);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    check("restart_bit_cnt", 64'(a_bit_cnt), 64'd0);
    check("restart_busy",    64'(a_busy),    64'd1);
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;

    // Stray start at bit_cnt 3, then async reset between edges at bit_cnt 20.
    load_a(0, -1, 20, 3);
    check("async_rst_en",      64'(a_en),      64'd0);
    check("async_rst_busy",    64'(a_busy),    64'd0);
    check("async_rst_bit_cnt", 64'(a_bit_cnt), 64'd0);
    #2 rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_idle", 64'(a_busy), 64'd0);

    // Abort beats start in IDLE; abort beats a handshake in LOAD.
    a_start = 1'b1; a_abort = 1'b1;
    step();
    a_start = 1'b0; a_abort = 1'b0;
    check("abort_over_start", 64'(a_busy), 64'd0);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    check("load_ready", 64'(a_if.in_ready), 64'd1);
    a_stream.delete();
    a_if.in_data = 8'hA5; a_if.in_valid = 1'b1; a_abort = 1'b1;
    step();
    a_if.in_valid = 1'b0; a_abort = 1'b0;
    check("hs_abort_busy",  64'(a_busy),          64'd0);
    check("hs_abort_ready", 64'(a_if.in_ready),   64'd0);
    repeat (10) step();
    check("hs_abort_no_en", 64'(a_stream.size()), 64'd0);

    // Truncated chain: 20 bits from three 0xFF words.
    b_stream.delete(); b_done_cnt = 0; b_max = 0; hs_b = 0; last_bits = 0; timed_out = 1;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (b_done_cnt > 0) begin timed_out = 0; break; end
      b_if.in_data  = 8'hFF;
      b_if.in_valid = (hs_b < 3);
      hs = b_if.in_valid && b_if.in_ready;
      step();
      if (hs) hs_b++;
      if (b_en && hs_b == 3) last_bits++;
    end
    b_if.in_valid = 1'b0;
    ones = 0;
    foreach (b_stream[i]) ones += int'(b_stream[i]);
    check("b_timeout",      64'(timed_out),        64'd0);
    check("b_en_cycles",    64'(b_stream.size()),  64'd20);
    check("b_ones",         64'(ones),             64'd20);
    check("b_words",        64'(hs_b),             64'd3);
    check("b_last_bits",    64'(last_bits),        64'd4);
    check("b_done_pulses",  64'(b_done_cnt),       64'd1);
    check("b_bit_cnt",      64'(b_bit_cnt),        64'd20);
    check("b_bit_cnt_max",  64'(b_max),            64'd20);
    step();
    check("b_after_done_busy", 64'(b_busy), 64'd0);

    check("head_zero_when_idle", 64'(head_err), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter WORD_W, default 8, SHALL set the width of the configuration word accepted per handshake.
REQ-002 Parameter CHAIN_LEN, default 64, SHALL set the total number of bits shifted into the configuration chain per load.
REQ-003 prog_clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 pReset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request a new chain load when sampled high in IDLE.
REQ-006 abort  input  1  SHALL cancel any load in progress when sampled high.
REQ-007 in_data  input  WORD_W  SHALL carry the configuration word; bit 0 is shifted first.
REQ-008 in_valid  input  1  SHALL qualify in_data.
REQ-009 in_ready  output  1  SHALL indicate that the block accepts in_data this cycle.
REQ-010 ccff_head  output  1  SHALL be the serial bit driven into the configuration-chain head.
REQ-011 ccff_en  output  1  SHALL be the chain shift enable; the chain advances one bit per cycle while it is high.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.
REQ-013 done  output  1  SHALL pulse high for one cycle when exactly CHAIN_LEN bits have been shifted.
REQ-014 bit_cnt  output  clog2(CHAIN_LEN+1)  SHALL report the number of bits shifted in the current load.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, SHIFT and DONE; all outputs SHALL be registered.
REQ-016 IDLE: in_ready=0 and ccff_en=0; start=1 -> LOAD with bit_cnt cleared to 0; start SHALL be ignored outside IDLE.
REQ-017 LOAD: in_ready=1; a handshake (in_valid & in_ready) SHALL capture in_data into the shift register and transition to SHIFT.
REQ-018 LOAD without in_valid: the FSM SHALL hold in LOAD indefinitely, with ccff_en=0 and the chain frozen.
REQ-019 SHIFT: each cycle, ccff_en=1, ccff_head=shreg[0], shreg shifts right by 1, and bit_cnt increments by 1; in_ready=0.
REQ-020 Latency: for a word accepted in cycle N, its bits SHALL appear on ccff_head with ccff_en=1 in cycles N+1 .. N+WORD_W, LSB first.
REQ-021 SHIFT exit: when bit_cnt reaches CHAIN_LEN -> DONE; else after WORD_W bits of the current word -> LOAD.
REQ-022 If CHAIN_LEN is not a multiple of WORD_W, the final word SHALL be truncated after CHAIN_LEN mod WORD_W bits, and its upper bits SHALL be discarded.
REQ-023 bit_cnt SHALL never exceed CHAIN_LEN and SHALL hold its final value through DONE until the next start.
REQ-024 DONE: done=1 for exactly one cycle, then -> IDLE; ccff_en=0 in DONE.
REQ-025 abort=1 in any state SHALL force -> IDLE on the next edge, with ccff_en=0, in_ready=0 and done=0; abort SHALL take priority over a simultaneous handshake or start.
REQ-026 A handshake and abort in the same cycle SHALL NOT capture in_data.
REQ-027 ccff_head SHALL be 0 whenever ccff_en=0.

Reset
REQ-028 pReset=0 SHALL asynchronously force state=IDLE, shreg=0, bit_cnt=0, ccff_head=0, ccff_en=0, in_ready=0, busy=0 and done=0.
REQ-029 Reset asserted mid-SHIFT SHALL drop ccff_en in the same cycle without waiting for a clock edge; the partial chain contents are then undefined and require a new load.
REQ-030 After pReset deassertion, the FSM SHALL remain in IDLE until start is sampled high.

Verification
REQ-031 Default parameters; start, then 8 words 0x01..0x08 presented with in_valid held high -> 64 ccff_en cycles, the serial stream equals the words LSB first, done pulses once, and bit_cnt=64.
REQ-032 in_valid low for 5 cycles between words 3 and 4 -> the FSM holds in LOAD, ccff_en=0 for those cycles, and the bit stream is identical to REQ-031.
REQ-033 CHAIN_LEN=20, WORD_W=8, words 0xFF,0xFF,0xFF -> exactly 20 ccff_en cycles, the last word shifts 4 bits, and done is then asserted.
REQ-034 abort asserted at bit_cnt=13 -> the next cycle shows IDLE with ccff_en=0 and busy=0, no done pulse, and the next start restarts with bit_cnt=0.
REQ-035 pReset pulsed low mid-SHIFT between clock edges -> ccff_en, busy and bit_cnt read 0 immediately; a start issued while busy is ignored, with no restart of bit_cnt.
REQ-036 Handshake and abort in the same cycle -> the word is not captured, the FSM enters IDLE, and no ccff_en pulse follows.
